alu_share_arbiter: RTL and testbench

- Shares one combinational ALU instance between two requesters, e.g. the execute stage and a multi-cycle helper unit.
- Each requester uses a valid/ready request handshake.
- The arbiter grants round-robin, registers the granted operation onto the ALU inputs, captures the ALU result and returns it on a single valid/ready response channel tagged with the requester id.
- Sits beside the ALU in the execute area; the ALU itself is unchanged.

---
 rtl/alu_share_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Define ALU_SHARE_FIXED_PRIO_EN for fixed priority (requester 0 always wins).
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [CTRL_WIDTH-1:0] req0_ctrl,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [CTRL_WIDTH-1:0] req1_ctrl,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic [CTRL_WIDTH-1:0] alu_control,
    output logic [DATA_WIDTH-1:0] alu_operand_a,
    output logic [DATA_WIDTH-1:0] alu_operand_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    // Handshakes: a transfer happens on the rising edge where valid and ready are
    // both high; valid may drop before ready without effect, payload is sampled
    // only on the transfer edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    id_q, id_d;
    logic [CTRL_WIDTH-1:0]   ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_id_q, resp_id_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
`ifndef ALU_SHARE_FIXED_PRIO_EN
    logic                    last_grant_q, last_grant_d;
`endif

    logic any_valid;
    logic grant_id;

    always_comb begin
        any_valid = req0_valid | req1_valid;
`ifdef ALU_SHARE_FIXED_PRIO_EN
        grant_id  = ~req0_valid;
`else
        // Contention goes to whoever did not win last; a lone requester always wins.
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = ~req0_valid;
        end
`endif
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && !grant_id;
    assign req1_ready = (state_q == IDLE) && req1_valid &&  grant_id;

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        ctrl_d       = ctrl_q;
        a_d          = a_q;
        b_d          = b_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
`ifndef ALU_SHARE_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    ctrl_d  = grant_id ? req1_ctrl : req0_ctrl;
                    a_d     = grant_id ? req1_a    : req0_a;
                    b_d     = grant_id ? req1_b    : req0_b;
                    id_d    = grant_id;
`ifndef ALU_SHARE_FIXED_PRIO_EN
                    last_grant_d = grant_id;
`endif
                    state_d = EXEC;
                end
            end
            EXEC: begin
                resp_data_d  = alu_result;
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            id_q         <= 1'b0;
            ctrl_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            ctrl_q       <= ctrl_d;
            a_q          <= a_d;
            b_q          <= b_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign alu_control   = ctrl_q;
    assign alu_operand_a = a_q;
    assign alu_operand_b = b_q;
    assign resp_valid    = resp_valid_q;
    assign resp_id       = resp_id_q;
    assign resp_data     = resp_data_q;
    assign busy          = (state_q != IDLE);
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with an adder standing in for the ALU.
module tb_alu_share_arbiter;

    localparam int DW = 32;
    localparam int CW = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [CW-1:0] req0_ctrl = '0, req1_ctrl = '0;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [CW-1:0] alu_control;
    logic [DW-1:0] alu_operand_a, alu_operand_b, alu_result;
    logic          resp_valid, resp_id, busy;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_data;
    logic [1:0]    state_dbg;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    assign alu_result = alu_operand_a + alu_operand_b;

    alu_share_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_control(alu_control), .alu_operand_a(alu_operand_a),
        .alu_operand_b(alu_operand_b), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .busy(busy), .state_dbg(state_dbg)
    );

    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid got %0b exp 0", resp_valid); end
        vectors++; if (resp_id !== 1'b0) begin miscompares++; $display("FAIL reset_resp_id got %0b exp 0", resp_id); end
        vectors++; if (resp_data !== 32'h0) begin miscompares++; $display("FAIL reset_resp_data got %h exp 0", resp_data); end
        vectors++; if (alu_control !== 6'h0) begin miscompares++; $display("FAIL reset_alu_control got %h exp 0", alu_control); end
        vectors++; if (alu_operand_a !== 32'h0 || alu_operand_b !== 32'h0) begin miscompares++; $display("FAIL reset_alu_operands got %h/%h exp 0/0", alu_operand_a, alu_operand_b); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b exp 0", busy); end
        vectors++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %0b%0b exp 00", req0_ready, req1_ready); end
        vectors++; if (state_dbg !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
    endtask

    task automatic test_single();
        resp_ready = 1'b1;
        req0_ctrl = 6'h00; req0_a = 32'h5; req0_b = 32'h7; req0_valid = 1'b1;
        #1;
        vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL single_ready got %0b%0b exp 10", req0_ready, req1_ready); end
        @(posedge clock);
        #1 req0_valid = 1'b0;
        vectors++; if (req0_ready !== 1'b0 || busy !== 1'b1 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL single_exec got rdy=%0b busy=%0b rv=%0b exp 0 1 0", req0_ready, busy, resp_valid); end
        vectors++; if (alu_operand_a !== 32'h5 || alu_operand_b !== 32'h7) begin miscompares++; $display("FAIL single_operands got %h/%h exp 5/7", alu_operand_a, alu_operand_b); end
        @(posedge clock);
        #1;
        vectors++; if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 32'h0000000C) begin miscompares++; $display("FAIL single_resp got v=%0b id=%0b d=%h exp 1 0 0000000c", resp_valid, resp_id, resp_data); end
        @(posedge clock);
        #1;
        vectors++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_idle got rv=%0b busy=%0b exp 0 0", resp_valid, busy); end
        vectors++; if (alu_operand_a !== 32'h5) begin miscompares++; $display("FAIL single_hold_operand got %h exp 5", alu_operand_a); end
    endtask

    task automatic test_simultaneous();
        logic          exp_g;
        logic [DW-1:0] exp_d;
        logic [CW-1:0] exp_c;
        apply_reset();
        resp_ready = 1'b1;
        req0_ctrl = 6'h01; req0_a = 32'h1;  req0_b = 32'h2;
        req1_ctrl = 6'h02; req1_a = 32'h10; req1_b = 32'h20;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
            exp_g = 1'b0;
`else
            exp_g = (i % 2 == 1);
`endif
            exp_d = exp_g ? 32'h30 : 32'h3;
            exp_c = exp_g ? 6'h02 : 6'h01;
            vectors++; if (req0_ready !== !exp_g || req1_ready !== exp_g) begin miscompares++; $display("FAIL sim_grant%0d got %0b%0b exp grant %0d", i, req0_ready, req1_ready, exp_g); end
            @(posedge clock);
            #1;
            vectors++; if (alu_control !== exp_c) begin miscompares++; $display("FAIL sim_ctrl%0d got %h exp %h", i, alu_control, exp_c); end
            @(posedge clock);
            #1;
            vectors++; if (resp_valid !== 1'b1 || resp_id !== exp_g || resp_data !== exp_d) begin miscompares++; $display("FAIL sim_resp%0d got v=%0b id=%0b d=%h exp 1 %0b %h", i, resp_valid, resp_id, resp_data, exp_g, exp_d); end
            @(posedge clock);
            #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        req0_ctrl = 6'h04; req0_a = 32'h9; req0_b = 32'h3; req0_valid = 1'b1;
        #1;
        vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL bp_accept got %0b exp 1", req0_ready); end
        @(posedge clock);
        #1 req0_valid = 1'b0; req1_valid = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 5; i++) begin
            vectors++; if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 32'h0000000C) begin miscompares++; $display("FAIL bp_hold%0d got v=%0b id=%0b d=%h exp 1 0 0000000c", i, resp_valid, resp_id, resp_data); end
            vectors++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL bp_block%0d got rdy=%0b%0b busy=%0b exp 00 1", i, req0_ready, req1_ready, busy); end
            @(posedge clock);
            #1;
        end
        resp_ready = 1'b1;
        #1;
        vectors++; if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL bp_no_accept_on_resp got %0b exp 0", req1_ready); end
        @(posedge clock);
        #1 req1_valid = 1'b0;
        vectors++; if (resp_valid !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0) begin miscompares++; $display("FAIL bp_release got rv=%0b busy=%0b st=%0d exp 0 0 0", resp_valid, busy, state_dbg); end
    endtask

    task automatic test_wrap();
        resp_ready = 1'b1;
        req1_ctrl = 6'h3F; req1_a = 32'hFFFFFFFF; req1_b = 32'h00000001; req1_valid = 1'b1;
        #1;
        vectors++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin miscompares++; $display("FAIL wrap_ready got %0b%0b exp 01", req0_ready, req1_ready); end
        @(posedge clock);
        #1 req1_valid = 1'b0;
        vectors++; if (alu_control !== 6'h3F) begin miscompares++; $display("FAIL wrap_ctrl got %h exp 3f", alu_control); end
        vectors++; if (alu_operand_a !== 32'hFFFFFFFF || alu_operand_b !== 32'h1) begin miscompares++; $display("FAIL wrap_operands got %h/%h exp ffffffff/00000001", alu_operand_a, alu_operand_b); end
        @(posedge clock);
        #1;
        vectors++; if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_data !== 32'h0) begin miscompares++; $display("FAIL wrap_resp got v=%0b id=%0b d=%h exp 1 1 00000000", resp_valid, resp_id, resp_data); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b1;
        req0_ctrl = 6'h05; req0_a = 32'h2; req0_b = 32'h2; req0_valid = 1'b1;
        #1;
        @(posedge clock);
        #1 req0_valid = 1'b0;
        vectors++; if (state_dbg !== 2'd1) begin miscompares++; $display("FAIL mid_in_exec got %0d exp 1", state_dbg); end
        reset = 1'b0;
        #1;
        vectors++; if (resp_valid !== 1'b0 || busy !== 1'b0 || alu_operand_a !== 32'h0) begin miscompares++; $display("FAIL mid_async got rv=%0b busy=%0b a=%h exp 0 0 0", resp_valid, busy, alu_operand_a); end
        @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_no_resp%0d got %0b exp 0", i, resp_valid); end
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_ctrl = 6'h11; req1_a = 32'h100; req1_b = 32'h23;
        #1;
        vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL mid_last_grant got %0b%0b exp 10", req0_ready, req1_ready); end
        req0_valid = 1'b0;
        #1;
        vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL mid_req1_grant got %0b exp 1", req1_ready); end
        @(posedge clock);
        #1 req1_valid = 1'b0;
        @(posedge clock);
        #1;
        vectors++; if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_data !== 32'h123) begin miscompares++; $display("FAIL mid_req1_resp got v=%0b id=%0b d=%h exp 1 1 00000123", resp_valid, resp_id, resp_data); end
        @(posedge clock);
        #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
